// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch state encoding and default address constants
package fetch_pkg;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_e;

   localparam int unsigned IMEM_DEPTH  = 256;
   localparam logic [31:0] RESET_PC    = 32'd0;
   localparam logic [31:0] EXC_VECTOR  = 32'h20;
   localparam int unsigned BOOT_CYCLES = 2;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC select: priority, wrap and target range check
module fetch_next_pc #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       IMEM_DEPTH = 256,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h20)
) (
   input  fetch_pkg::state_e    state_i,
   input  logic [ADDR_W-1:0]    pc_i,
   input  logic                 stall_i,
   input  logic                 jmp_i,
   input  logic [ADDR_W-1:0]    jmp_target_i,
   input  logic                 br_taken_i,
   input  logic [ADDR_W-1:0]    br_target_i,
   input  logic                 exc_i,
   input  logic                 halt_i,
   output logic [ADDR_W-1:0]    next_pc_o,
   output logic                 redirect_o,
   output logic                 range_err_o
);
   import fetch_pkg::*;

   logic [ADDR_W-1:0] tgt;
   logic              tgt_bad;
   logic [ADDR_W-1:0] pc_inc;

   // Branch resolves later in the pipe than jump, so it wins when both fire.
   assign tgt     = br_taken_i ? br_target_i : jmp_target_i;
   assign tgt_bad = 64'(tgt) >= 64'(IMEM_DEPTH);
   assign pc_inc  = (pc_i == ADDR_W'(IMEM_DEPTH - 1)) ? '0 : pc_i + 1'b1;

   always_comb begin
      next_pc_o   = pc_i;
      redirect_o  = 1'b0;
      range_err_o = 1'b0;
      case (state_i)
         S_RUN: begin
            if (exc_i) begin
               next_pc_o  = EXC_VECTOR;
               redirect_o = 1'b1;
            end else if (br_taken_i || jmp_i) begin
               redirect_o = 1'b1;
               if (tgt_bad) begin
                  next_pc_o   = EXC_VECTOR;
                  range_err_o = 1'b1;
               end else begin
                  next_pc_o = tgt;
               end
            end else if (!halt_i && !stall_i) begin
               next_pc_o = pc_inc;
            end
         end
         S_HALT: begin
            if (exc_i) begin
               next_pc_o  = EXC_VECTOR;
               redirect_o = 1'b1;
            end
         end
         default: next_pc_o = pc_i;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter, boot hold-off, halt and IF slot tagging
module fetch_pc_unit #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       IMEM_DEPTH  = fetch_pkg::IMEM_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(fetch_pkg::RESET_PC),
   parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(fetch_pkg::EXC_VECTOR),
   parameter int unsigned       BOOT_CYCLES = fetch_pkg::BOOT_CYCLES
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              stall_i,
   input  logic              jmp_i,
   input  logic [ADDR_W-1:0] jmp_target_i,
   input  logic              br_taken_i,
   input  logic [ADDR_W-1:0] br_target_i,
   input  logic              exc_i,
   input  logic              halt_i,
   output logic [ADDR_W-1:0] ImemRdAddr,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic              if_valid_o,
   output logic              flush_o,
   output logic              addr_err_o,
   output logic [31:0]       fetch_cnt_o
);
   import fetch_pkg::*;

   localparam int unsigned    BCW       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [BCW-1:0]    boot_cnt_q, boot_cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic              if_valid_q, if_valid_d;
   logic              addr_err_q, addr_err_d;
   logic [31:0]       fetch_cnt_q, fetch_cnt_d;

   logic [ADDR_W-1:0] next_pc;
   logic              redirect;
   logic              range_err;
   logic              slot_ok;
   logic              slot_hold;

   fetch_next_pc #(
      .ADDR_W     (ADDR_W),
      .IMEM_DEPTH (IMEM_DEPTH),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc (
      .state_i      (state_q),
      .pc_i         (pc_q),
      .stall_i      (stall_i),
      .jmp_i        (jmp_i),
      .jmp_target_i (jmp_target_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .exc_i        (exc_i),
      .halt_i       (halt_i),
      .next_pc_o    (next_pc),
      .redirect_o   (redirect),
      .range_err_o  (range_err)
   );

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      pc_d        = next_pc;
      if_pc_d     = pc_q;
      if_valid_d  = 1'b0;
      fetch_cnt_d = fetch_cnt_q;
      addr_err_d  = addr_err_q | range_err;
      slot_ok     = 1'b0;
      slot_hold   = 1'b0;
      case (state_q)
         S_BOOT: begin
            boot_cnt_d = boot_cnt_q + 1'b1;
            if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            if (!redirect && halt_i) state_d = S_HALT;
            slot_ok   = !redirect && !halt_i;
            slot_hold = stall_i && !redirect && !halt_i;
         end
         S_HALT: begin
            if (exc_i) state_d = S_RUN;
         end
         default: state_d = S_BOOT;
      endcase
      // A stall re-reads the same word, so the tag already in IF stays put.
      if (slot_hold) begin
         if_pc_d    = if_pc_q;
         if_valid_d = if_valid_q;
      end else begin
         if_valid_d = slot_ok;
         if (slot_ok) fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= S_BOOT;
         boot_cnt_q  <= '0;
         pc_q        <= RESET_PC;
         if_pc_q     <= '0;
         if_valid_q  <= 1'b0;
         addr_err_q  <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         pc_q        <= pc_d;
         if_pc_q     <= if_pc_d;
         if_valid_q  <= if_valid_d;
         addr_err_q  <= addr_err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign ImemRdAddr  = pc_q;
   assign if_pc_o     = if_pc_q;
   assign if_valid_o  = if_valid_q;
   assign addr_err_o  = addr_err_q;
   assign fetch_cnt_o = fetch_cnt_q;
   assign flush_o     = (state_q == S_RUN || state_q == S_HALT) && (exc_i || br_taken_i);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed-vector scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

   logic        Clk;
   logic        Rst;
   logic        stall_i;
   logic        jmp_i;
   logic [31:0] jmp_target_i;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        exc_i;
   logic        halt_i;
   logic [31:0] ImemRdAddr;
   logic [31:0] if_pc_o;
   logic        if_valid_o;
   logic        flush_o;
   logic        addr_err_o;
   logic [31:0] fetch_cnt_o;

   fetch_pc_unit dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .stall_i      (stall_i),
      .jmp_i        (jmp_i),
      .jmp_target_i (jmp_target_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .exc_i        (exc_i),
      .halt_i       (halt_i),
      .ImemRdAddr   (ImemRdAddr),
      .if_pc_o      (if_pc_o),
      .if_valid_o   (if_valid_o),
      .flush_o      (flush_o),
      .addr_err_o   (addr_err_o),
      .fetch_cnt_o  (fetch_cnt_o)
   );

   typedef struct {
      int          row;
      logic [31:0] addr;
      logic [31:0] pc;
      logic        v;
      logic        fl;
      logic [31:0] cnt;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   row_no = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
      end
   endtask

   // Each row: inputs held for one cycle, plus the outputs expected during that cycle.
   task automatic row(input logic rst, input logic st, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt, input logic ex, input logic hl,
                      input logic [31:0] ea, input logic [31:0] ep, input logic ev,
                      input logic ef, input logic [31:0] ec, input logic ee);
      exp_t e;
      @(posedge Clk);
      #2;
      Rst          = rst;
      stall_i      = st;
      jmp_i        = j;
      jmp_target_i = jt;
      br_taken_i   = b;
      br_target_i  = bt;
      exc_i        = ex;
      halt_i       = hl;
      e.row  = row_no;
      e.addr = ea;
      e.pc   = ep;
      e.v    = ev;
      e.fl   = ef;
      e.cnt  = ec;
      e.err  = ee;
      exp_q.push_back(e);
      row_no++;
   endtask

   task automatic idle(input logic [31:0] ea, input logic [31:0] ep, input logic ev,
                       input logic [31:0] ec, input logic ee);
      row(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, ea, ep, ev, 1'b0, ec, ee);
   endtask

   always @(negedge Clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("imem_addr", e.row, ImemRdAddr, e.addr);
         chk("if_pc", e.row, if_pc_o, e.pc);
         chk("if_valid", e.row, {31'd0, if_valid_o}, {31'd0, e.v});
         chk("flush", e.row, {31'd0, flush_o}, {31'd0, e.fl});
         chk("fetch_cnt", e.row, fetch_cnt_o, e.cnt);
         chk("addr_err", e.row, {31'd0, addr_err_o}, {31'd0, e.err});
      end
   end

   initial begin
      Rst          = 1'b0;
      stall_i      = 1'b0;
      jmp_i        = 1'b0;
      jmp_target_i = '0;
      br_taken_i   = 1'b0;
      br_target_i  = '0;
      exc_i        = 1'b0;
      halt_i       = 1'b0;

      // reset held three cycles, then boot hold-off
      for (int i = 0; i < 3; i++)
         row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      idle(0, 0, 1'b0, 0, 1'b0);
      idle(0, 0, 1'b0, 0, 1'b0);
      idle(0, 0, 1'b0, 0, 1'b0);
      idle(1, 0, 1'b1, 1, 1'b0);
      for (int a = 2; a <= 4; a++) idle(a, a - 1, 1'b1, a, 1'b0);

      // two-cycle stall at pc 5
      row(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5, 4, 1'b1, 1'b0, 5, 1'b0);
      row(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 5, 4, 1'b1, 1'b0, 5, 1'b0);
      idle(5, 4, 1'b1, 5, 1'b0);
      for (int a = 6; a <= 9; a++) idle(a, a - 1, 1'b1, a, 1'b0);

      // taken branch overrides a simultaneous stall
      row(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd40, 1'b0, 1'b0, 10, 9, 1'b1, 1'b1, 10, 1'b0);
      idle(40, 10, 1'b0, 10, 1'b0);

      // jump without flush, then exception beating a jump
      row(1'b1, 1'b0, 1'b1, 32'd12, 1'b0, 32'd0, 1'b0, 1'b0, 41, 40, 1'b1, 1'b0, 11, 1'b0);
      row(1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 32'd0, 1'b1, 1'b0, 12, 41, 1'b0, 1'b1, 11, 1'b0);
      idle(32'h20, 12, 1'b0, 11, 1'b0);

      // wrap at the top of memory, then an out-of-range jump
      row(1'b1, 1'b0, 1'b1, 32'd250, 1'b0, 32'd0, 1'b0, 1'b0, 33, 32, 1'b1, 1'b0, 12, 1'b0);
      idle(250, 33, 1'b0, 12, 1'b0);
      for (int a = 251; a <= 255; a++) idle(a, a - 1, 1'b1, a - 238, 1'b0);
      row(1'b1, 1'b0, 1'b1, 32'd300, 1'b0, 32'd0, 1'b0, 1'b0, 0, 255, 1'b1, 1'b0, 18, 1'b0);
      idle(32'h20, 0, 1'b0, 18, 1'b1);

      // halt at pc 50 ignores jump/branch/stall; only an exception leaves
      row(1'b1, 1'b0, 1'b1, 32'd50, 1'b0, 32'd0, 1'b0, 1'b0, 33, 32, 1'b1, 1'b0, 19, 1'b1);
      row(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 50, 33, 1'b0, 1'b0, 19, 1'b1);
      row(1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 50, 50, 1'b0, 1'b0, 19, 1'b1);
      row(1'b1, 1'b1, 1'b1, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 50, 50, 1'b0, 1'b0, 19, 1'b1);
      row(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'd9, 1'b0, 1'b0, 50, 50, 1'b0, 1'b1, 19, 1'b1);
      row(1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 50, 50, 1'b0, 1'b0, 19, 1'b1);
      row(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 50, 50, 1'b0, 1'b1, 19, 1'b1);
      idle(32'h20, 50, 1'b0, 19, 1'b1);
      idle(33, 32, 1'b1, 20, 1'b1);

      // asynchronous reset mid-run; redirects during boot are ignored
      row(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      row(1'b1, 1'b0, 1'b1, 32'd9, 1'b0, 32'd0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      row(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      idle(0, 0, 1'b0, 0, 1'b0);
      idle(1, 0, 1'b1, 1, 1'b0);

      @(negedge Clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end that sits directly upstream of the instruction memory. It owns the program counter and drives the word-index read address. It also produces a PC and valid tag aligned with the memory's registered Instruction output, so the IF/ID register can capture the pair together. It resolves stalls, jump/branch/exception redirects, boot hold-off and halt.

Parameters:
ADDR_W, 32, width of PC and all address ports (word index, not byte address)
IMEM_DEPTH, 256, number of instruction words; the PC wraps modulo this value
RESET_PC, 0, word index fetched first after boot
EXC_VECTOR, 32'h20, word index of the exception handler
BOOT_CYCLES, 2, clock edges after reset release during which fetch is held invalid

Ports:
Clk  in  1  clock; all state changes on posedge
Rst  in  1  asynchronous, active-low reset
stall_i  in  1  hazard stall from ID; hold the PC
jmp_i  in  1  jump resolved in ID
jmp_target_i  in  ADDR_W  jump target word index
br_taken_i  in  1  taken branch resolved in EX
br_target_i  in  ADDR_W  branch target word index
exc_i  in  1  exception request
halt_i  in  1  break/halt request from ID
ImemRdAddr  out  ADDR_W  read address to the instruction memory; equals pc_q
if_pc_o  out  ADDR_W  word index of the instruction currently on the memory output
if_valid_o  out  1  memory output is a live (non-squashed) instruction
flush_o  out  1  combinational; squash the IF/ID register this cycle
addr_err_o  out  1  sticky; a redirect target was >= IMEM_DEPTH
fetch_cnt_o  out  32  count of valid fetches

Behaviour:
- Rst=0 (asynchronous) forces: pc_q=RESET_PC, state=S_BOOT, boot_cnt=0, if_pc_o=0, if_valid_o=0, addr_err_o=0, fetch_cnt_o=0.
- Alignment: the memory samples ImemRdAddr at edge k. At the same edge, if_pc_o<=pc_q and if_valid_o<=slot_ok. After edge k, Instruction, if_pc_o and if_valid_o describe the same slot. Fetch latency is 1 cycle.
- S_BOOT: pc_q holds and if_valid_o<=0. boot_cnt increments each edge. When boot_cnt==BOOT_CYCLES-1, go to S_RUN. exc_i, halt_i and redirects are ignored in S_BOOT.
- S_RUN, next-PC priority, highest first:
  - exc_i: go to EXC_VECTOR.
  - br_taken_i: go to br_target_i.
  - jmp_i: go to jmp_target_i.
  - halt_i: go to S_HALT, pc_q holds.
  - stall_i: pc_q holds.
  - Otherwise: (pc_q+1) mod IMEM_DEPTH. pc_q=IMEM_DEPTH-1 wraps to 0.
- Redirects override stall.
- slot_ok=0 on any redirect edge: the slot sampled at that edge is wrong-path.
- On a stall edge (no redirect), if_pc_o and if_valid_o hold their values. The memory re-reads the same word.
- flush_o = exc_i | br_taken_i while in S_RUN or S_HALT; 0 in S_BOOT. jmp_i does not assert flush_o; only the in-flight IF slot is squashed.
- Target range check: a selected branch or jump target >= IMEM_DEPTH sets addr_err_o=1 and loads EXC_VECTOR instead. addr_err_o is cleared only by reset.
- S_HALT: pc_q holds and if_valid_o<=0 every edge. stall_i, jmp_i and br_taken_i are ignored. Only exc_i exits: pc_q<=EXC_VECTOR, state goes to S_RUN, slot_ok=0.
- fetch_cnt_o increments on each edge where if_valid_o is loaded with 1 and the edge is not a stall hold. It wraps at 2^32.
- Reset asserted mid-operation aborts immediately to reset values; no partial redirect survives.

Decomposition:
- Shared package fetch_pkg holds:
  - the state encoding: S_BOOT=2'd0, S_RUN=2'd1, S_HALT=2'd2;
  - the default constants RESET_PC, EXC_VECTOR and IMEM_DEPTH, shared with the instruction memory and the exception logic.
- One natural sub-module: fetch_next_pc. It is purely combinational and implements priority select, wrap and range check, outputting next_pc, redirect and range_err.

Test Plan:
- Reset held 3 cycles, then released -> ImemRdAddr=0; if_valid_o=0 for 2 edges; at the 3rd edge if_pc_o=0 and if_valid_o=1; then if_pc_o steps 1,2,3.
- Run to pc_q=5, assert stall_i for 2 cycles -> ImemRdAddr stays 5; if_pc_o and if_valid_o held; fetch_cnt_o unchanged; resumes 6 after release.
- pc_q=10, br_taken_i=1 with br_target_i=40 and stall_i=1 in the same cycle -> flush_o=1 that cycle; next ImemRdAddr=40; the slot for 10 is tagged if_valid_o=0; the next slot is 40 valid.
- exc_i and jmp_i (target 7) together at pc_q=12 -> ImemRdAddr=32'h20; flush_o=1.
- Run to pc_q=255 -> next ImemRdAddr=0, valid. Then jmp_i with target 300 -> addr_err_o=1 and ImemRdAddr=32'h20.
- halt_i at pc_q=50 -> if_valid_o=0 and ImemRdAddr=50 for 5 cycles despite jmp_i; then exc_i -> ImemRdAddr=32'h20, state S_RUN.
